// File: rtl/multdiv_issue_ctrl.sv
// multdiv_issue_ctrl: pipeline-side initiator for the iterative multdiv unit.
// Accepts one MUL/DIV request, holds operands, emits a one-cycle start pulse,
// waits for resultRDY and hands the result to writeback over valid/ready.
// Optional watchdog abort is compiled in with `define MULTDIV_TIMEOUT_EN.
module multdiv_issue_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 20,
    parameter int unsigned REG_ADDR_W     = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_div,
    input  logic [31:0]           req_opA,
    input  logic [31:0]           req_opB,
    input  logic [REG_ADDR_W-1:0] req_rd,
    output logic [31:0]           md_operandA,
    output logic [31:0]           md_operandB,
    output logic                  md_ctrl_MULT,
    output logic                  md_ctrl_DIV,
    input  logic [31:0]           md_result,
    input  logic                  md_exception,
    input  logic                  md_resultRDY,
    output logic                  stall,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [31:0]           wb_data,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  wb_exc,
    output logic                  wb_timeout
);

    typedef enum logic [1:0] {StIdle, StStart, StBusy, StDone} state_e;

    state_e                  state_q, state_d;
    logic [31:0]             op_a_q, op_a_d;
    logic [31:0]             op_b_q, op_b_d;
    logic                    is_div_q, is_div_d;
    logic [REG_ADDR_W-1:0]   rd_q, rd_d;
    logic                    ctrl_mult_q, ctrl_mult_d;
    logic                    ctrl_div_q, ctrl_div_d;
    logic                    wb_valid_q, wb_valid_d;
    logic [31:0]             wb_data_q, wb_data_d;
    logic [REG_ADDR_W-1:0]   wb_rd_q, wb_rd_d;
    logic                    wb_exc_q, wb_exc_d;

`ifdef MULTDIV_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            wb_tmo_q, wb_tmo_d;
`endif

    // Next-state and datapath capture; the start pulse is registered so it
    // is high exactly while in StStart.
    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        is_div_d    = is_div_q;
        rd_d        = rd_q;
        ctrl_mult_d = 1'b0;
        ctrl_div_d  = 1'b0;
        wb_valid_d  = wb_valid_q;
        wb_data_d   = wb_data_q;
        wb_rd_d     = wb_rd_q;
        wb_exc_d    = wb_exc_q;
`ifdef MULTDIV_TIMEOUT_EN
        cnt_d       = cnt_q;
        wb_tmo_d    = wb_tmo_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    op_a_d      = req_opA;
                    op_b_d      = req_opB;
                    is_div_d    = req_is_div;
                    rd_d        = req_rd;
                    ctrl_mult_d = ~req_is_div;
                    ctrl_div_d  = req_is_div;
                    state_d     = StStart;
                end
            end
            StStart: begin
                // RDY here may be stale from a previous op; the pulse clears the unit.
                state_d = StBusy;
`ifdef MULTDIV_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            StBusy: begin
                if (md_resultRDY) begin
                    wb_data_d  = md_result;
                    wb_exc_d   = md_exception;
                    wb_rd_d    = rd_q;
                    wb_valid_d = 1'b1;
`ifdef MULTDIV_TIMEOUT_EN
                    wb_tmo_d   = 1'b0;
`endif
                    state_d    = StDone;
                end
`ifdef MULTDIV_TIMEOUT_EN
                else if (cnt_q == CntLast) begin
                    wb_data_d  = '0;
                    wb_exc_d   = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_valid_d = 1'b1;
                    wb_tmo_d   = 1'b1;
                    state_d    = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
`endif
            end
            StDone: begin
                if (wb_ready) begin
                    wb_valid_d = 1'b0;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            op_a_q      <= '0;
            op_b_q      <= '0;
            is_div_q    <= 1'b0;
            rd_q        <= '0;
            ctrl_mult_q <= 1'b0;
            ctrl_div_q  <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= '0;
            wb_rd_q     <= '0;
            wb_exc_q    <= 1'b0;
`ifdef MULTDIV_TIMEOUT_EN
            cnt_q       <= '0;
            wb_tmo_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            is_div_q    <= is_div_d;
            rd_q        <= rd_d;
            ctrl_mult_q <= ctrl_mult_d;
            ctrl_div_q  <= ctrl_div_d;
            wb_valid_q  <= wb_valid_d;
            wb_data_q   <= wb_data_d;
            wb_rd_q     <= wb_rd_d;
            wb_exc_q    <= wb_exc_d;
`ifdef MULTDIV_TIMEOUT_EN
            cnt_q       <= cnt_d;
            wb_tmo_q    <= wb_tmo_d;
`endif
        end
    end

    assign req_ready    = (state_q == StIdle);
    assign stall        = (state_q != StIdle);
    assign md_operandA  = op_a_q;
    assign md_operandB  = op_b_q;
    assign md_ctrl_MULT = ctrl_mult_q;
    assign md_ctrl_DIV  = ctrl_div_q;
    assign wb_valid     = wb_valid_q;
    assign wb_data      = wb_data_q;
    assign wb_rd        = wb_rd_q;
    assign wb_exc       = wb_exc_q;
`ifdef MULTDIV_TIMEOUT_EN
    assign wb_timeout   = wb_tmo_q;
`else
    assign wb_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Self-checking bench for multdiv_issue_ctrl: transaction-level model compared
// every negedge, plus directed literal checks per scenario.
module tb_multdiv_issue_ctrl;

    localparam int TMO = 20;

    logic        clock, reset;
    logic        req_valid, req_ready, req_is_div;
    logic [31:0] req_opA, req_opB;
    logic [4:0]  req_rd;
    logic [31:0] md_operandA, md_operandB;
    logic        md_ctrl_MULT, md_ctrl_DIV;
    logic [31:0] md_result;
    logic        md_exception, md_resultRDY;
    logic        stall, wb_valid, wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_exc, wb_timeout;

    int n_pass = 0;
    int n_total = 0;

    multdiv_issue_ctrl #(.TIMEOUT_CYCLES(TMO), .REG_ADDR_W(5)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_div(req_is_div),
        .req_opA(req_opA), .req_opB(req_opB), .req_rd(req_rd),
        .md_operandA(md_operandA), .md_operandB(md_operandB),
        .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
        .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
        .stall(stall), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_data(wb_data), .wb_rd(wb_rd), .wb_exc(wb_exc), .wb_timeout(wb_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Transaction model: one op in flight; age counts cycles since accept
    // (1 = pulse cycle, >=2 = waiting for RDY).
    bit          m_inflight, m_pend, m_div, m_exc, m_tmo;
    int          m_age;
    logic [31:0] m_a, m_b, m_data;
    logic [4:0]  m_rq, m_rd;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_inflight <= 0; m_pend <= 0; m_div <= 0; m_exc <= 0; m_tmo <= 0;
            m_age <= 0; m_a <= 0; m_b <= 0; m_data <= 0; m_rq <= 0; m_rd <= 0;
        end else if (!m_inflight) begin
            if (req_valid) begin
                m_inflight <= 1; m_age <= 1;
                m_a <= req_opA; m_b <= req_opB; m_div <= req_is_div; m_rq <= req_rd;
            end
        end else if (!m_pend) begin
            if (m_age >= 2 && md_resultRDY) begin
                m_pend <= 1; m_data <= md_result; m_exc <= md_exception;
                m_rd <= m_rq; m_tmo <= 0;
            end
`ifdef MULTDIV_TIMEOUT_EN
            else if (m_age == TMO + 1) begin
                m_pend <= 1; m_data <= 0; m_exc <= 1; m_rd <= m_rq; m_tmo <= 1;
            end
`endif
            else m_age <= m_age + 1;
        end else if (wb_ready) begin
            m_pend <= 0; m_inflight <= 0;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clock) begin
        check("cyc_req_ready", req_ready, !m_inflight);
        check("cyc_stall", stall, m_inflight);
        check("cyc_opA", md_operandA, m_a);
        check("cyc_opB", md_operandB, m_b);
        check("cyc_mult", md_ctrl_MULT, m_inflight && m_age == 1 && !m_div);
        check("cyc_div", md_ctrl_DIV, m_inflight && m_age == 1 && m_div);
        check("cyc_wb_valid", wb_valid, m_pend);
        check("cyc_wb_data", wb_data, m_data);
        check("cyc_wb_rd", wb_rd, m_rd);
        check("cyc_wb_exc", wb_exc, m_exc);
        check("cyc_wb_timeout", wb_timeout, m_tmo);
    end

    // Issue one op; the multdiv stand-in raises RDY lat cycles after BUSY entry.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic div,
                          input logic [4:0] rd, input int lat, input int hold,
                          input bit stale, input bit junk, input bit early);
        int sa, sb;
        logic [31:0] res;
        logic exc;
        sa = a; sb = b;
        if (div) begin
            exc = (b == 0);
            res = exc ? 32'd0 : 32'(sa / sb);
        end else begin
            exc = 1'b0;
            res = a * b;
        end
        wb_ready = early;
        req_valid = 1; req_is_div = div; req_opA = a; req_opB = b; req_rd = rd;
        @(posedge clock); #1;
        req_valid = 0;
        check("accept_stall", stall, 1);
        check("accept_opA", md_operandA, a);
        check("accept_opB", md_operandB, b);
        check("pulse_mult", md_ctrl_MULT, !div);
        check("pulse_div", md_ctrl_DIV, div);
        if (stale) begin md_resultRDY = 1; md_result = 32'hdeadbeef; md_exception = 1; end
        @(posedge clock); #1;
        md_resultRDY = 0; md_exception = 0;
        check("pulse_end", {md_ctrl_MULT, md_ctrl_DIV}, 0);
        check("no_early_valid", wb_valid, 0);
        repeat (lat - 1) @(posedge clock);
        #1;
        md_resultRDY = 1; md_result = res; md_exception = exc;
        @(posedge clock); #1;
        md_resultRDY = 0; md_exception = 0; md_result = $urandom();
        check("wb_valid_rise", wb_valid, 1);
        check("wb_data", wb_data, res);
        check("wb_rd", wb_rd, rd);
        check("wb_exc", wb_exc, exc);
        if (junk) begin
            req_valid = 1; req_is_div = 0; req_opA = 32'h1111; req_opB = 32'h2222; req_rd = 5'd2;
        end
        repeat (hold) begin
            @(posedge clock); #1;
            check("hold_valid", wb_valid, 1);
            check("hold_data", wb_data, res);
            check("hold_no_accept", req_ready, 0);
        end
        wb_ready = 1;
        @(posedge clock); #1;
        wb_ready = 0;
        check("wb_consumed", wb_valid, 0);
        check("back_idle", req_ready, 1);
    endtask

    initial begin
        reset = 1; req_valid = 0; req_is_div = 0; req_opA = 0; req_opB = 0; req_rd = 0;
        md_result = 0; md_exception = 0; md_resultRDY = 0; wb_ready = 0;
        repeat (2) @(posedge clock);
        #1 reset = 0;
        check("rst_req_ready", req_ready, 1);
        check("rst_stall", stall, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_timeout", wb_timeout, 0);
        @(posedge clock); #1;

        // MUL 7*6, 16-cycle unit
        run_op(32'd7, 32'd6, 1'b0, 5'd3, 16, 0, 0, 0, 0);
        check("t1_data", wb_data, 32'd42);
        check("t1_rd", wb_rd, 32'd3);
        check("t1_exc", wb_exc, 0);

        // DIV by zero
        run_op(32'd100, 32'd0, 1'b1, 5'd9, 16, 0, 0, 0, 0);
        check("t2_data", wb_data, 32'd0);
        check("t2_rd", wb_rd, 32'd9);
        check("t2_exc", wb_exc, 1);

        // Backpressure with a request waiting, accepted right after
        run_op(32'h12345678, 32'd3, 1'b0, 5'd31, 5, 5, 0, 1, 0);
        check("t3_data", wb_data, 32'h369d0368);
        run_op(-32'sd100, 32'd7, 1'b1, 5'd1, 4, 0, 0, 0, 0);
        check("t3b_data", wb_data, 32'hfffffff2);

        // Stale RDY during START ignored
        run_op(32'd2, 32'hffffffff, 1'b0, 5'd5, 3, 0, 1, 0, 0);
        check("t4_data", wb_data, 32'hfffffffe);

        // Reset in BUSY
        req_valid = 1; req_is_div = 1; req_opA = 32'd50; req_opB = 32'd5; req_rd = 5'd12;
        @(posedge clock); #1 req_valid = 0;
        @(posedge clock); #1;
        check("t5_busy_stall", stall, 1);
        #1 reset = 1;
        #1;
        check("t5_rst_ready", req_ready, 1);
        check("t5_rst_stall", stall, 0);
        check("t5_rst_opA", md_operandA, 0);
        check("t5_rst_opB", md_operandB, 0);
        check("t5_rst_ctrl", {md_ctrl_MULT, md_ctrl_DIV}, 0);
        check("t5_rst_valid", wb_valid, 0);
        check("t5_rst_data", wb_data, 0);
        check("t5_rst_rd", wb_rd, 0);
        check("t5_rst_exc", wb_exc, 0);
        @(posedge clock); #1 reset = 0;
        @(posedge clock); #1;
        // wb_ready held high outside DONE has no effect
        run_op(-32'sd3, 32'd5, 1'b0, 5'd7, 1, 0, 0, 0, 1);
        check("t5_data", wb_data, 32'hfffffff1);
        check("t5_timeout", wb_timeout, 0);

`ifdef MULTDIV_TIMEOUT_EN
        begin
            int n;
            bit got;
            req_valid = 1; req_is_div = 0; req_opA = 32'd5; req_opB = 32'd5; req_rd = 5'd4;
            @(posedge clock); #1 req_valid = 0;
            n = 0; got = 0;
            while (!got && n < 40) begin
                @(posedge clock); #1;
                n++;
                if (wb_valid) got = 1;
            end
            check("t6_edges", n, TMO + 1);
            check("t6_exc", wb_exc, 1);
            check("t6_timeout", wb_timeout, 1);
            check("t6_data", wb_data, 0);
            check("t6_rd", wb_rd, 32'd4);
            wb_ready = 1;
            @(posedge clock); #1 wb_ready = 0;
            // RDY on the terminal cycle wins
            run_op(32'd9, 32'd9, 1'b0, 5'd6, TMO, 0, 0, 0, 0);
            check("t6b_data", wb_data, 32'd81);
            check("t6b_timeout", wb_timeout, 0);
        end
`endif

        repeat (2) @(posedge clock);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
